wb_stage: RTL
=============

// Module: wb_stage
// PURPOSE
//   MEM/WB pipeline register plus writeback: captures the MEM-stage result, aligns and extends load data,
//   and drives the register file write port (rd_addr / Regwrite / Write_data). Keeps a retired-instruction
//   counter and can bypass the same-cycle write into the decode read ports. Sits between MEM and Reg_file.
// PARAMETERS
//   XLEN      32  datapath width (only 32 is supported)
//   CNT_W     64  width of instret_count
// PORTS
//   clk             in   1      rising-edge clock
//   reset_n         in   1      reset, synchronous, active-low
//   stall           in   1      hold the MEM/WB register; suppress retire this cycle
//   flush           in   1      bubble: clear wb_valid at next edge (priority over stall)
//   mem_valid       in   1      MEM stage holds a real instruction
//   mem_regwrite    in   1      instruction writes rd
//   mem_rd_addr     in   5      destination register
//   mem_wb_sel      in   2      result source, encoded by WB_SEL_* constants
//   mem_funct3      in   3      load size/sign, encoded by LD_* constants
//   mem_alu_result  in   XLEN   ALU result; [1:0] is the load byte offset
//   mem_load_data   in   XLEN   raw aligned data word from memory
//   mem_pc_plus4    in   XLEN   link value for JAL/JALR
//   rd_addr         out  5      register file write address
//   Regwrite        out  1      register file write enable
//   Write_data      out  XLEN   register file write data
//   rs1_addr        in   5      decode read address 1
//   rs2_addr        in   5      decode read address 2
//   rf_rdata1       in   XLEN   Reg_file Read_data1
//   rf_rdata2       in   XLEN   Reg_file Read_data2
//   byp_rdata1      out  XLEN   operand 1 to decode
//   byp_rdata2      out  XLEN   operand 2 to decode
//   instret_count   out  CNT_W  retired-instruction count
// BEHAVIOUR
//   - Reset (reset_n=0 at an edge): wb_valid, all WB fields, and instret_count are cleared to 0. As a
//     result Regwrite=0, rd_addr=0, and Write_data=0. Reset mid-stall or mid-flush also wins.
//   - Edge update, in priority order: !reset_n > flush (wb_valid<=0, other fields don't-care) > stall (hold)
//     > capture all mem_* fields, with wb_valid<=mem_valid.
//   - retire = wb_valid & !stall. Regwrite = retire & wb_regwrite & (rd_addr!=0). rd_addr = WB field.
//   - Latency: a value captured at edge N is written into Reg_file at edge N+1.
//   - flush asserted in the same cycle does not cancel an instruction already in WB: it retires normally.
//   - Write_data is combinational from the WB fields:
//     WB_SEL_ALU=00 gives alu_result; WB_SEL_LOAD=01 gives aligned load; WB_SEL_PC4=10 gives pc_plus4;
//     11 gives 0.
//   - Load align, with off = alu_result[1:0]:
//     LB/LBU take byte `off`, sign- or zero-extended.
//     LH/LHU take the half selected by off[1] (off[0] ignored), sign- or zero-extended.
//     LW returns the whole word (off ignored).
//     Any other funct3 returns the raw word.
//   - instret_count increments by 1 on every retire cycle and wraps from all-ones to 0.
//     Stalled or invalid cycles do not count.
// CONFIGURATION
//   WB_BYPASS_EN defined:
//     byp_rdataN = (Regwrite && rsN_addr==rd_addr) ? Write_data : rf_rdataN.
//     No bypass is applied for rsN_addr==0.
//   WB_BYPASS_EN undefined: byp_rdataN = rf_rdataN (pure pass-through). The ports exist in both builds.
// STRUCTURE
//   riscv_pkg: WB_SEL_ALU/LOAD/PC4 (2b), LD_LB=000 LD_LH=001 LD_LW=010 LD_LBU=100 LD_LHU=101.
//   Sub-module load_align (combinational; inputs word, off[1:0], funct3; output extended data).
//   It is instantiated once inside wb_stage.
// TESTING
//   1. reset_n=0 for 2 cycles with mem_valid=1 -> Regwrite=0, Write_data=0, instret_count=0.
//   2. ALU op: rd=5, alu=0x1234_5678, sel=ALU -> next cycle Regwrite=1, rd_addr=5, Write_data=0x1234_5678,
//      count=1.
//   3. Load word=0x8081_7F01:
//      LB off=1 -> 0x0000_007F; LB off=3 -> 0xFFFF_FF80; LHU off=2 -> 0x0000_8081;
//      LH off=0 -> 0x0000_7F01.
//   4. rd=0 with regwrite=1 -> Regwrite=0, count still increments.
//      mem_valid=0 -> no write, no count.
//   5. stall held 3 cycles on a valid op -> Regwrite=0 and WB held throughout, then one write and
//      count+1 on release.
//      flush together with stall -> bubble at next edge.
//   6. WB_BYPASS_EN: rd=7 writing 0xDEAD_BEEF, rs1=7, rf_rdata1=0x1 -> byp_rdata1=0xDEAD_BEEF.
//      rs2=0 with rd=0 -> byp_rdata2=rf_rdata2.
//      Without the macro -> byp_rdata1=0x1.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - writeback select and load-size encodings shared by the wb stage
package riscv_pkg;

  localparam int XLEN_DEF = 32;

  // Result source for the register file write
  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;

  // Load size / sign (funct3)
  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  // Fields carried in the MEM/WB pipeline register
  typedef struct packed {
    logic        regwrite;
    logic [4:0]  rd;
    logic [1:0]  wb_sel;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] load_data;
    logic [31:0] pc_plus4;
  } wb_fields_t;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - picks and extends the byte/half/word addressed by a load
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte chosen by the full offset, half chosen by off[1] only
  always_comb begin
    byte_sel = word[{off, 3'b000} +: 8];
    half_sel = off[1] ? word[31:16] : word[15:0];
  end

  // Extension by load type; unknown funct3 passes the raw word through
  always_comb begin
    data = word;
    case (funct3)
      LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  data = {24'h0, byte_sel};
      LD_LH:   data = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  data = {16'h0, half_sel};
      LD_LW:   data = word;
      default: data = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB register, writeback mux, retire counter; WB_BYPASS_EN adds decode bypass
module wb_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic             mem_regwrite,
  input  logic [4:0]       mem_rd_addr,
  input  logic [1:0]       mem_wb_sel,
  input  logic [2:0]       mem_funct3,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_load_data,
  input  logic [XLEN-1:0]  mem_pc_plus4,
  output logic [4:0]       rd_addr,
  output logic             Regwrite,
  output logic [XLEN-1:0]  Write_data,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  input  logic [XLEN-1:0]  rf_rdata1,
  input  logic [XLEN-1:0]  rf_rdata2,
  output logic [XLEN-1:0]  byp_rdata1,
  output logic [XLEN-1:0]  byp_rdata2,
  output logic [CNT_W-1:0] instret_count
);

  logic        wb_valid;
  wb_fields_t  wb;
  logic        retire;
  logic [31:0] load_ext;

  assign retire   = wb_valid & ~stall;
  assign Regwrite = retire & wb.regwrite & (wb.rd != 5'd0);
  assign rd_addr  = wb.rd;

  // Pipeline register: reset > flush > stall(hold) > capture; counter tracks retires
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wb_valid      <= 1'b0;
      wb            <= '0;
      instret_count <= '0;
    end else begin
      if (retire) begin
        instret_count <= instret_count + CNT_W'(1);
      end
      if (flush) begin
        wb_valid <= 1'b0;
      end else if (!stall) begin
        wb_valid      <= mem_valid;
        wb.regwrite   <= mem_regwrite;
        wb.rd         <= mem_rd_addr;
        wb.wb_sel     <= mem_wb_sel;
        wb.funct3     <= mem_funct3;
        wb.alu_result <= mem_alu_result;
        wb.load_data  <= mem_load_data;
        wb.pc_plus4   <= mem_pc_plus4;
      end
    end
  end

  load_align u_load_align (
    .word   (wb.load_data),
    .off    (wb.alu_result[1:0]),
    .funct3 (wb.funct3),
    .data   (load_ext)
  );

  // Writeback source select; the reserved encoding writes zero
  always_comb begin
    Write_data = '0;
    case (wb.wb_sel)
      WB_SEL_ALU:  Write_data = wb.alu_result;
      WB_SEL_LOAD: Write_data = load_ext;
      WB_SEL_PC4:  Write_data = wb.pc_plus4;
      default:     Write_data = '0;
    endcase
  end

`ifdef WB_BYPASS_EN
  // Forward the write happening this cycle to a matching decode read (x0 never forwarded)
  always_comb begin
    byp_rdata1 = rf_rdata1;
    byp_rdata2 = rf_rdata2;
    if (Regwrite && rs1_addr == rd_addr && rs1_addr != 5'd0) byp_rdata1 = Write_data;
    if (Regwrite && rs2_addr == rd_addr && rs2_addr != 5'd0) byp_rdata2 = Write_data;
  end
`else
  logic unused_rs;
  assign unused_rs = ^{rs1_addr, rs2_addr};

  // Without bypass the register file data goes straight through
  always_comb begin
    byp_rdata1 = rf_rdata1;
    byp_rdata2 = rf_rdata2;
  end
`endif

endmodule
